// File: rtl/spi_master_ctrl_if.sv
// Fabric request/response handshake plus SPI pins for spi_master_ctrl.
// The master modport is the controller's view; slave is the fabric/SPI-slave side.
interface spi_master_ctrl_if;
  logic       req;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;
  logic       busy;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic       verify_err;

  modport master (
    input  req, rw, addr, wdata, miso,
    output ack, rdata, busy, sclk, cs, mosi, verify_err
  );

  modport slave (
    output req, rw, addr, wdata, miso,
    input  ack, rdata, busy, sclk, cs, mosi, verify_err
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Single-byte SPI read/write sequencer with a slow, divided SCLK (mode 0, MSB first).
// Define SPIM_VERIFY_EN to follow every write with an automatic readback frame and compare.
module spi_master_ctrl #(
  parameter int unsigned HALF_PERIOD = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_ctrl_if.master bus
);

  localparam int unsigned   CW      = $clog2(2 * HALF_PERIOD);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_M1  = CW'(2 * HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_HI,
    S_SHIFT_LO,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          rw_q, rw_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          cnt_zero;

`ifdef SPIM_VERIFY_EN
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rb_q, rb_d;
  logic          verr_q, verr_d;
`endif

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    rdata_d = rdata_q;
`ifdef SPIM_VERIFY_EN
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rb_d    = rb_q;
    verr_d  = verr_q;
`endif

    // Every phase reloads the divider on exit, so the count never drifts across bits.
    if (state_q != S_IDLE) begin
      cnt_d = cnt_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          rw_d    = bus.rw;
          tx_d    = {bus.addr, bus.rw, bus.rw ? 8'h00 : bus.wdata};
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = HALF_M1;
          state_d = S_SETUP;
`ifdef SPIM_VERIFY_EN
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          rb_d    = 1'b0;
          verr_d  = 1'b0;
`endif
        end
      end

      S_SETUP: begin
        if (cnt_zero) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], bus.miso};
          bit_d   = '0;
          cnt_d   = HALF_M1;
          state_d = S_SHIFT_HI;
        end
      end

      S_SHIFT_HI: begin
        if (cnt_zero) begin
          sclk_d  = 1'b0;
          tx_d    = {tx_q[14:0], 1'b0};
          cnt_d   = HALF_M1;
          state_d = S_SHIFT_LO;
        end
      end

      S_SHIFT_LO: begin
        if (cnt_zero) begin
          cnt_d = HALF_M1;
          if (bit_q == 4'd15) begin
            state_d = S_HOLD;
          end else begin
            sclk_d  = 1'b1;
            rx_d    = {rx_q[6:0], bus.miso};
            bit_d   = bit_q + 1'b1;
            state_d = S_SHIFT_HI;
          end
        end
      end

      S_HOLD: begin
        if (cnt_zero) begin
          cs_d    = 1'b1;
          tx_d    = '0;
          cnt_d   = GAP_M1;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (cnt_zero) begin
`ifdef SPIM_VERIFY_EN
          // A finished write frame chains straight into a read of the same address.
          if (!rw_q && !rb_q) begin
            rb_d    = 1'b1;
            tx_d    = {addr_q, 1'b1, 8'h00};
            cs_d    = 1'b0;
            cnt_d   = HALF_M1;
            state_d = S_SETUP;
          end else begin
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            rdata_d = rx_q;
            verr_d  = rb_q && (rx_q != wdata_q);
            cnt_d   = '0;
            state_d = S_IDLE;
          end
`else
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rw_q) begin
            rdata_d = rx_q;
          end
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rw_q    <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
`ifdef SPIM_VERIFY_EN
      addr_q  <= '0;
      wdata_q <= '0;
      rb_q    <= 1'b0;
      verr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rw_q    <= rw_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
`ifdef SPIM_VERIFY_EN
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rb_q    <= rb_d;
      verr_q  <= verr_d;
`endif
    end
  end

  // MOSI is the head of the transmit shifter, which is zero outside a frame.
  assign bus.mosi  = tx_q[15];
  assign bus.sclk  = sclk_q;
  assign bus.cs    = cs_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = rdata_q;
`ifdef SPIM_VERIFY_EN
  assign bus.verify_err = verr_q;
`else
  assign bus.verify_err = 1'b0;
`endif

  a_ack_not_busy : assert property (@(posedge clk) disable iff (!rst_n) ack_q |-> !busy_q);
  a_idle_pins    : assert property (@(posedge clk) disable iff (!rst_n) (state_q == S_IDLE) |-> (cs_q && !sclk_q));
  a_sclk_in_cs   : assert property (@(posedge clk) disable iff (!rst_n) sclk_q |-> !cs_q);

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Transaction sequencer that drives the SPI memory slave from the FPGA fabric.
- Accepts single-byte read/write requests on a req/ack handshake.
- Generates a slow SCLK, active-low CS and MOSI frame; samples MISO; returns read data.
- SCLK is slow because the slave passes SCLK, CS and MOSI through its input conditioners, which add latency.

Parameters:
HALF_PERIOD, 32, clk cycles per SCLK half-period; legal values are 2 and above.

Ports:
clk  input  1  system clock; the block's only clock
rst_n  input  1  asynchronous, active-low reset
req  input  1  transaction request; sampled only when busy=0
rw  input  1  1=read, 0=write; captured with req
addr  input  7  memory address; captured with req
wdata  input  8  write data; captured with req
ack  output  1  one-cycle pulse at transaction completion
rdata  output  8  read result; held until the next accepted read
busy  output  1  high while a transaction is in progress
sclk  output  1  SPI clock; idles low
cs  output  1  SPI chip select, active low; idles high
mosi  output  1  SPI master out
miso  input  1  SPI master in
verify_err  output  1  readback mismatch flag; constant 0 unless SPIM_VERIFY_EN is defined

Behaviour:
- Reset (asynchronous, on rst_n low): state=IDLE, sclk=0, cs=1, mosi=0, ack=0, busy=0, rdata=0x00, verify_err=0. All counters clear.
- Frame: 16 bits, MSB first.
  - Bits 15..8 = {addr[6:0], rw}.
  - Bits 7..0 = wdata on a write, 0x00 on a read.
- Mode: SCLK idles low. MOSI changes only on SCLK falling edges, plus the first bit in SETUP. MISO is sampled on SCLK rising edges.
- States:
  - IDLE: on req=1 (busy=0), capture rw/addr/wdata, busy=1, go to SETUP. req while busy=1 is ignored, not queued.
  - SETUP: cs=0, mosi=frame[15], sclk=0; HALF_PERIOD cycles.
  - SHIFT: 16 bits, bit counter 0..15. Per bit: sclk=1 for HALF_PERIOD cycles, shifting miso into rx_shift on the cycle sclk rises; then sclk=0 for HALF_PERIOD cycles, presenting the next frame bit on mosi at the fall. After bit 15's low phase, go to HOLD.
  - HOLD: sclk=0, cs=0; HALF_PERIOD cycles.
  - GAP: cs=1, mosi=0; 2*HALF_PERIOD cycles, then go to IDLE with ack=1 for one cycle.
- Latency: ack asserts exactly 36*HALF_PERIOD cycles after the accepting clk edge. busy falls in the same cycle ack rises.
- A req present in the ack cycle is accepted, so back-to-back transactions are legal.
- rdata:
  - Loaded from rx_shift[7:0] (the last 8 MISO samples, first sample = bit 7) at ack, on reads only.
  - Unchanged on writes.
  - MISO samples taken during the address byte are discarded.
- Divider counter width is $clog2(2*HALF_PERIOD). It reloads on every phase change, with no drift across bits.
- rst_n asserted mid-frame: cs returns high and sclk low immediately (asynchronous). No ack is issued; the partial frame is abandoned.
- Inputs other than req are don't-care outside the accept cycle.

Optional Feature:
- Macro: SPIM_VERIFY_EN.
- Defined:
  - A write transaction is followed automatically by a read frame of the same addr: SETUP..GAP again, with no IDLE between.
  - ack is delayed to 72*HALF_PERIOD cycles after the accepting edge.
  - rdata receives the readback byte.
  - verify_err = (readback != wdata), updated at ack and held until the next accepted req clears it.
  - Reads behave as without the macro and clear verify_err at accept.
- Undefined: no readback frame; verify_err is tied to 0.

Test Plan:
- Reset: hold rst_n=0 -> cs=1, sclk=0, mosi=0, busy=0, ack=0, rdata=0x00. Release; 10 idle cycles -> no output changes.
- Write, HALF_PERIOD=4: addr=0x15, wdata=0xA5, rw=0 -> MOSI sampled at SCLK rises = 0x2A then 0xA5. Exactly 16 SCLK pulses; cs low throughout. ack one cycle at accept+144; busy low at the same cycle.
- Read: addr=0x15, rw=1, slave model returns 0x3C -> MOSI = 0x2B, 0x00; rdata=0x3C at ack. A following write leaves rdata=0x3C.
- Busy rejection: pulse req again 20 cycles after accept, with different addr -> ignored; only one frame is emitted. req held high in the ack cycle -> second frame starts next cycle.
- Reset mid-frame: assert rst_n after bit 5 -> cs=1 and sclk=0 in the same cycle, no ack. A new write after release produces a complete, correct frame.
- SPIM_VERIFY_EN: write 0x5A with the slave returning 0x5A -> two frames, ack at accept+72*HALF_PERIOD, verify_err=0. Slave corrupted to return 0x5B -> verify_err=1, rdata=0x5B.
